// File: rtl/bcd_converter_seq_if.sv
// ---------------------------------------------------------------------------
// bcd_converter_seq_if
// Handshake and data bundle between the processor datapath and the sequential
// binary-to-BCD converter.
//
// Signals:
//   Start    request a conversion (driven by master)
//   Valor    W-bit binary value to convert (driven by master)
//   Busy     conversion in progress (driven by slave)
//   Done     one-cycle pulse, Digitos just updated (driven by slave)
//   Digitos  packed BCD, [3:0] = units, [7:4] = tens, ... (driven by slave)
//   Negativo sign of the last converted value (driven by slave)
//
// Modports:
//   master  requester side (datapath / testbench)
//   slave   converter side
// ---------------------------------------------------------------------------
interface bcd_converter_seq_if #(
   parameter int W      = 16,
   parameter int DIGITS = 5
);
   logic                  Start;
   logic [W-1:0]          Valor;
   logic                  Busy;
   logic                  Done;
   logic [4*DIGITS-1:0]   Digitos;
   logic                  Negativo;

   modport master (
      output Start,
      output Valor,
      input  Busy,
      input  Done,
      input  Digitos,
      input  Negativo
   );

   modport slave (
      input  Start,
      input  Valor,
      output Busy,
      output Done,
      output Digitos,
      output Negativo
   );
endinterface

// File: rtl/bcd_converter_seq.sv
// ---------------------------------------------------------------------------
// bcd_converter_seq
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit
// per clock. Feeds packed decimal nibbles to the 7-segment decoders.
//
// Ports:
//   Clock   single system clock, rising edge
//   Resetn  synchronous, active-low reset
//   bus     bcd_converter_seq_if.slave: Start, Valor in; Busy, Done,
//           Digitos, Negativo out (all outputs registered)
//
// Parameters:
//   W       binary input width (>= 4)
//   DIGITS  number of BCD digits, 10^DIGITS > 2^W - 1
//
// Optional feature macro: BCD_CONVERTER_SIGNED_EN
//   defined   -> Valor is two's complement; magnitude is converted and the
//                sign is reported on Negativo.
//   undefined -> Valor is unsigned, Negativo is tied to 0.
//
// Timeline (accepting edge E0): Busy high after E0, W shifts at E1..EW,
// the FSM sits in DONE for one cycle, and at E(W+1) Digitos/Done update.
// The DONE cycle accepts a new Start, so a held Start gives one result
// every W+1 cycles.
// ---------------------------------------------------------------------------
module bcd_converter_seq #(
   parameter int W      = 16,
   parameter int DIGITS = 5
) (
   input  logic               Clock,
   input  logic               Resetn,
   bcd_converter_seq_if.slave bus
);
   localparam int CW = $clog2(W + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state_reg,   state_next;
   logic [W-1:0]    bin_reg,     bin_next;
   logic [BW-1:0]   scratch_reg, scratch_next;
   logic [CW-1:0]   cnt_reg,     cnt_next;
   logic [BW-1:0]   digitos_reg, digitos_next;
   logic            busy_reg,    busy_next;
   logic            done_reg,    done_next;
   logic [BW-1:0]   corrected;
   logic [W-1:0]    load_value;
   logic            accept;

`ifdef BCD_CONVERTER_SIGNED_EN
   logic            sign_reg, sign_next;
   logic            neg_reg,  neg_next;
   logic            load_sign;

   // Negative inputs are converted as their W-bit magnitude; the most
   // negative value wraps to itself, which read unsigned is 2^(W-1).
   assign load_sign  = bus.Valor[W-1];
   assign load_value = load_sign ? (~bus.Valor + W'(1)) : bus.Valor;
`else
   assign load_value = bus.Valor;
`endif

   // Add-3 correction on every nibble >= 5, applied combinationally ahead
   // of the registered shift so one bit is consumed per clock.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign corrected[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                       ? scratch_reg[4*gi +: 4] + 4'd3
                                       : scratch_reg[4*gi +: 4];
      end
   endgenerate

   // State and datapath registers
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_reg   <= IDLE;
         bin_reg     <= '0;
         scratch_reg <= '0;
         cnt_reg     <= '0;
         digitos_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
`ifdef BCD_CONVERTER_SIGNED_EN
         sign_reg    <= 1'b0;
         neg_reg     <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         bin_reg     <= bin_next;
         scratch_reg <= scratch_next;
         cnt_reg     <= cnt_next;
         digitos_reg <= digitos_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
`ifdef BCD_CONVERTER_SIGNED_EN
         sign_reg    <= sign_next;
         neg_reg     <= neg_next;
`endif
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_next   = state_reg;
      bin_next     = bin_reg;
      scratch_next = scratch_reg;
      cnt_next     = cnt_reg;
      digitos_next = digitos_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      accept       = 1'b0;
`ifdef BCD_CONVERTER_SIGNED_EN
      sign_next    = sign_reg;
      neg_next     = neg_reg;
`endif

      case (state_reg)
         IDLE: begin
            if (bus.Start) begin
               accept = 1'b1;
            end
         end

         SHIFT: begin
            // Start is deliberately not looked at here: requests made while
            // busy are dropped, not queued.
            {scratch_next, bin_next} = {corrected, bin_reg} << 1;
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg == CW'(1)) begin
               state_next = DONE;
               busy_next  = 1'b0;
            end
         end

         DONE: begin
            digitos_next = scratch_reg;
            done_next    = 1'b1;
`ifdef BCD_CONVERTER_SIGNED_EN
            neg_next     = sign_reg;
`endif
            if (bus.Start) begin
               accept = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase

      if (accept) begin
         bin_next     = load_value;
         scratch_next = '0;
         cnt_next     = CW'(W);
         state_next   = SHIFT;
         busy_next    = 1'b1;
`ifdef BCD_CONVERTER_SIGNED_EN
         sign_next    = load_sign;
`endif
      end
   end

   assign bus.Busy    = busy_reg;
   assign bus.Done    = done_reg;
   assign bus.Digitos = digitos_reg;
`ifdef BCD_CONVERTER_SIGNED_EN
   assign bus.Negativo = neg_reg;
`else
   assign bus.Negativo = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_converter_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_converter_seq
// Self-checking bench for bcd_converter_seq (W=16, DIGITS=5). Expected
// results come from decimal arithmetic on the input value (divide/modulo
// by 10), independent of the shift-add-3 datapath. Works in both the
// unsigned build and with BCD_CONVERTER_SIGNED_EN defined.
// ---------------------------------------------------------------------------
module tb_bcd_converter_seq;
   localparam int W      = 16;
   localparam int DIGITS = 5;

   logic Clock;
   logic Resetn;

   bcd_converter_seq_if #(.W(W), .DIGITS(DIGITS)) bus ();

   bcd_converter_seq #(.W(W), .DIGITS(DIGITS)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int passed = 0;
   int total  = 0;
   logic [19:0] last_result = '0;

   // ---------------- reference model ----------------
   function automatic int unsigned model_mag(input logic [15:0] v);
`ifdef BCD_CONVERTER_SIGNED_EN
      if (v[15]) return 32'd65536 - 32'(v);
`endif
      return 32'(v);
   endfunction

   function automatic logic model_neg(input logic [15:0] v);
`ifdef BCD_CONVERTER_SIGNED_EN
      return v[15];
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [19:0] model_bcd(input int unsigned m);
      logic [19:0] r;
      int unsigned x;
      r = '0;
      x = m;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Full conversion from IDLE with latency, busy-length and result checks.
   task automatic convert(input logic [15:0] v, input string tag);
      int k;
      int busy_n;
      logic [19:0] exp_d;
      exp_d = model_bcd(model_mag(v));
      bus.Valor = v;
      bus.Start = 1'b1;
      tick();                     // accepting edge E0
      bus.Start = 1'b0;
      busy_n = (bus.Busy === 1'b1) ? 1 : 0;
      k = 0;
      while (bus.Done !== 1'b1 && k < 40) begin
         tick();
         k++;
         if (bus.Busy === 1'b1) busy_n++;
      end
      check({tag, "_latency"}, 32'(k), 32'd17);
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
      check({tag, "_digitos"}, 32'(bus.Digitos), 32'(exp_d));
      check({tag, "_negativo"}, 32'(bus.Negativo), 32'(model_neg(v)));
      $display("conv %s: valor=%h digitos=%h negativo=%0b latency=%0d",
               tag, v, bus.Digitos, bus.Negativo, k);
      last_result = exp_d;
      tick();
      check({tag, "_done_drop"}, 32'(bus.Done), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k;
      int pulses;
      logic [19:0] seen;
      logic [15:0] rv;

      Resetn    = 1'b0;
      bus.Start = 1'b0;
      bus.Valor = '0;
      tick(); tick(); tick();
      check("rst_busy",     32'(bus.Busy),     32'd0);
      check("rst_done",     32'(bus.Done),     32'd0);
      check("rst_digitos",  32'(bus.Digitos),  32'd0);
      check("rst_negativo", 32'(bus.Negativo), 32'd0);
      Resetn = 1'b1;
      tick();

      // Basic and boundary values
      convert(16'd0,     "zero");
      convert(16'hFFFF,  "ffff");
      convert(16'd1234,  "v1234");
      convert(16'h8000,  "v8000");
      convert(16'd100,   "v100");
      convert(16'd9999,  "v9999");
      convert(16'd10000, "v10000");
      convert(16'h7FFF,  "v7fff");

      // Start re-pulsed during SHIFT must be ignored
      bus.Valor = 16'd5000;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      tick(); tick(); tick(); tick();
      bus.Valor = 16'd9;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      pulses = 0;
      seen   = '0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.Done === 1'b1) begin
            pulses++;
            seen = bus.Digitos;
         end
      end
      check("ignore_pulses",  32'(pulses), 32'd1);
      check("ignore_digitos", 32'(seen),   32'(model_bcd(32'd5000)));
      $display("conv ignore: digitos=%h pulses=%0d", seen, pulses);
      last_result = model_bcd(32'd5000);

      // Start held high, Valor stepping 0..21
      bus.Valor = 16'd0;
      bus.Start = 1'b1;
      tick();
      bus.Valor = 16'd1;
      for (int i = 0; i <= 21; i++) begin
         k = 0;
         do begin
            tick();
            k++;
         end while (bus.Done !== 1'b1 && k < 40);
         // the edge that raised Done also accepted value i+1
         bus.Valor = 16'(i + 2);
         if (i == 20) bus.Start = 1'b0;
         check($sformatf("held%0d_period", i), 32'(k), 32'd17);
         check($sformatf("held%0d_digitos", i), 32'(bus.Digitos), 32'(model_bcd(32'(i))));
         $display("conv held: valor=%0d digitos=%h period=%0d", i, bus.Digitos, k);
      end
      tick();
      check("held_end_busy", 32'(bus.Busy), 32'd0);
      last_result = model_bcd(32'd21);

      // Reset at cycle 8 of a conversion aborts it
      bus.Valor = 16'd777;
      bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("abort_hold_digitos", 32'(bus.Digitos), 32'(last_result));
      check("abort_busy_before",  32'(bus.Busy),    32'd1);
      Resetn = 1'b0;
      tick();
      check("abort_busy",    32'(bus.Busy),    32'd0);
      check("abort_digitos", 32'(bus.Digitos), 32'd0);
      check("abort_done",    32'(bus.Done),    32'd0);
      Resetn = 1'b1;
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (bus.Done === 1'b1) pulses++;
      end
      check("abort_no_done", 32'(pulses), 32'd0);
      $display("conv abort: digitos=%h done_pulses=%0d", bus.Digitos, pulses);
      convert(16'd42, "after_abort");

      // Randomized values against the decimal model
      for (int i = 0; i < 10; i++) begin
         rv = 16'($urandom_range(0, 65535));
         convert(rv, $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
